// File: rtl/multichannel_mixer_pkg.sv
// Shared DSP constants and types for the multichannel complex mixer.
package multichannel_mixer_pkg;
  localparam int DSZ_DEFAULT = 16;
  localparam int NCH_DEFAULT = 4;
  localparam int MIX_LATENCY = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    ISSUE1,
    ISSUE2,
    ISSUE3
  } mix_state_e;

  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multichannel_mixer_saturator.sv
// Signed saturator: clamps an ISZ-bit value into OSZ bits.
module multichannel_mixer_saturator #(
  parameter int ISZ = 17,
  parameter int OSZ = 16
) (
  input  logic signed [ISZ-1:0] din,
  output logic signed [OSZ-1:0] dout
);
  localparam int XB = ISZ - OSZ + 1;

  logic [XB-1:0] top;

  assign top = din[ISZ-1:OSZ-1];

  // In range when every bit above the output MSB repeats the sign.
  always_comb begin
    if (top == {XB{1'b0}} || top == {XB{1'b1}}) dout = din[OSZ-1:0];
    else if (din[ISZ-1])                         dout = {1'b1, {(OSZ-1){1'b0}}};
    else                                         dout = {1'b0, {(OSZ-1){1'b1}}};
  end
endmodule

// File: rtl/multichannel_mixer.sv
// Complex mixer: one shared multiplier issues a sample's four cross products
// over four cycles, then recombines them with optional LO conjugation.
module multichannel_mixer
  import multichannel_mixer_pkg::*;
#(
  parameter int DSZ = DSZ_DEFAULT,
  parameter int NCH = NCH_DEFAULT,
  localparam int CHW = chan_width(NCH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [DSZ-1:0] in_i,
  input  logic signed [DSZ-1:0] in_q,
  input  logic signed [DSZ-1:0] lo_i,
  input  logic signed [DSZ-1:0] lo_q,
  input  logic [CHW-1:0]        in_ch,
  input  logic [NCH-1:0]        conj_mask,
  input  logic [NCH-1:0]        bypass_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [DSZ-1:0] out_i,
  output logic signed [DSZ-1:0] out_q,
  output logic [CHW-1:0]        out_ch
);
  typedef struct packed {
    logic [CHW-1:0]        ch;
    logic                  conj;
    logic                  bypass;
    logic signed [DSZ-1:0] i;
    logic signed [DSZ-1:0] q;
  } meta_t;

  localparam logic signed [2*DSZ-1:0] RND = {{(DSZ+1){1'b0}}, 1'b1, {(DSZ-2){1'b0}}};

  mix_state_e              state, state_nx;
  logic                    adv, accept;
  logic [CHW-1:0]          ch_eff;
  meta_t                   op_meta, meta1, meta2;
  logic signed [DSZ-1:0]   op_lo_i, op_lo_q, mul_a, mul_b;
  logic signed [2*DSZ-1:0] prod, prod_rnd;
  logic signed [DSZ-1:0]   p_sat, sat_i, sat_q;
  logic signed [DSZ+1:0]   p_ext, acc_i, acc_q;
  logic signed [DSZ-1:0]   d0_i, d0_q, d1_i, d1_q;
  logic [CHW-1:0]          d0_ch, d1_ch;
  logic [MIX_LATENCY:0]    vld_pipe;
  logic                    unused_bits;

  // A result waiting on the consumer freezes every stage.
  assign out_valid = vld_pipe[MIX_LATENCY];
  assign adv       = !(out_valid && !out_ready);
  assign in_ready  = !reset && adv && (state == IDLE || state == ISSUE3);
  assign accept    = in_valid && in_ready;
  assign ch_eff    = (int'(in_ch) < NCH) ? in_ch : '0;

  always_ff @(posedge clk) begin
    if (reset)    state <= IDLE;
    else if (adv) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mul_a    = op_meta.i;
    mul_b    = op_lo_i;
    case (state)
      IDLE:   if (accept) state_nx = ISSUE0;
      ISSUE0: state_nx = ISSUE1;
      ISSUE1: begin
        state_nx = ISSUE2;
        mul_a    = op_meta.q;
        mul_b    = op_lo_q;
      end
      ISSUE2: begin
        state_nx = ISSUE3;
        mul_b    = op_lo_q;
      end
      ISSUE3: begin
        state_nx = accept ? ISSUE0 : IDLE;
        mul_a    = op_meta.q;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign prod_rnd = prod + RND;
  assign p_ext    = (DSZ+2)'(p_sat);

  multichannel_mixer_saturator #(.ISZ(DSZ+1), .OSZ(DSZ)) u_sat_prod (
    .din  (prod_rnd[2*DSZ-1:DSZ-1]),
    .dout (p_sat)
  );

  multichannel_mixer_saturator #(.ISZ(DSZ+1), .OSZ(DSZ)) u_sat_i (
    .din  (acc_i[DSZ+1:1]),
    .dout (sat_i)
  );

  multichannel_mixer_saturator #(.ISZ(DSZ+1), .OSZ(DSZ)) u_sat_q (
    .din  (acc_q[DSZ+1:1]),
    .dout (sat_q)
  );

  // vld_pipe[k] marks a sample accepted k edges ago; products land in prod
  // one edge after their ISSUE state, so stage k consumes the k-th product.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      op_meta  <= '0;
      op_lo_i  <= '0;
      op_lo_q  <= '0;
      meta1    <= '0;
      meta2    <= '0;
      prod     <= '0;
      acc_i    <= '0;
      acc_q    <= '0;
      d0_i     <= '0;
      d0_q     <= '0;
      d0_ch    <= '0;
      d1_i     <= '0;
      d1_q     <= '0;
      d1_ch    <= '0;
      out_i    <= '0;
      out_q    <= '0;
      out_ch   <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[MIX_LATENCY-1:0], accept};
      prod     <= (2*DSZ)'(mul_a) * (2*DSZ)'(mul_b);
      if (accept) begin
        op_meta.ch     <= in_ch;
        op_meta.conj   <= conj_mask[ch_eff];
        op_meta.bypass <= bypass_mask[ch_eff];
        op_meta.i      <= in_i;
        op_meta.q      <= in_q;
        op_lo_i        <= lo_i;
        op_lo_q        <= lo_q;
      end
      if (vld_pipe[0]) meta1 <= op_meta;
      if (vld_pipe[1]) acc_i <= p_ext;
      if (vld_pipe[2]) acc_i <= meta1.conj ? acc_i + p_ext : acc_i - p_ext;
      if (vld_pipe[3]) acc_q <= meta1.conj ? -p_ext : p_ext;
      // meta1 may be reloaded by the next sample on this same edge.
      if (vld_pipe[4]) begin
        acc_q <= acc_q + p_ext;
        meta2 <= meta1;
      end
      if (vld_pipe[5]) begin
        d0_i  <= meta2.bypass ? meta2.i : sat_i;
        d0_q  <= meta2.bypass ? meta2.q : sat_q;
        d0_ch <= meta2.ch;
      end
      if (vld_pipe[6]) begin
        d1_i  <= d0_i;
        d1_q  <= d0_q;
        d1_ch <= d0_ch;
      end
      if (vld_pipe[7]) begin
        out_i  <= d1_i;
        out_q  <= d1_q;
        out_ch <= d1_ch;
      end
    end
  end

  assign unused_bits = ^{acc_i[0], acc_q[0], prod_rnd[DSZ-2:0], meta2.conj};
endmodule

// File: tb/tb_multichannel_mixer.sv
// Directed and randomized checks of multichannel_mixer against an arithmetic model.
module tb_multichannel_mixer;
  import multichannel_mixer_pkg::*;

  localparam int DSZ = 16;
  localparam int NCH = 3;
  localparam int CHW = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic signed [DSZ-1:0] in_i = '0, in_q = '0, lo_i = '0, lo_q = '0;
  logic [CHW-1:0]        in_ch = '0;
  logic [NCH-1:0]        conj_mask = '0, bypass_mask = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic signed [DSZ-1:0] out_i, out_q;
  logic [CHW-1:0]        out_ch;

  typedef struct {
    longint i;
    longint q;
    int     ch;
    int     edge_no;
    bit     lat;
  } exp_t;

  exp_t   expq[$];
  int     tests = 0, fails = 0, cyc = 0;
  bit     lat_chk = 0, gap_chk = 0, head_seen = 0, rnd_done = 0;
  int     last_hs = -1, last_ch = 0;
  longint last_i = 0, last_q = 0;

  multichannel_mixer #(.DSZ(DSZ), .NCH(NCH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_i        (in_i),
    .in_q        (in_q),
    .lo_i        (lo_i),
    .lo_q        (lo_q),
    .in_ch       (in_ch),
    .conj_mask   (conj_mask),
    .bypass_mask (bypass_mask),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_i       (out_i),
    .out_q       (out_q),
    .out_ch      (out_ch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint act, input longint exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint fdiv(input longint a, input longint b);
    longint q = a / b;
    if ((a % b) != 0 && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic longint pscale(input longint x, input longint y);
    return sat(fdiv(x * y + (longint'(1) << (DSZ - 2)), longint'(1) << (DSZ - 1)));
  endfunction

  // Complex product x*lo (or x*conj(lo)) halved, each term rounded and clamped.
  function automatic exp_t model(input longint xi, input longint xq, input longint li,
                                 input longint lq, input int ch, input logic [NCH-1:0] cm,
                                 input logic [NCH-1:0] bm, input int edge_no, input bit lat);
    exp_t   e;
    int     m = (ch < NCH) ? ch : 0;
    longint pii = pscale(xi, li), pqq = pscale(xq, lq);
    longint piq = pscale(xi, lq), pqi = pscale(xq, li);
    e.ch = ch;
    e.edge_no = edge_no;
    e.lat = lat;
    if (bm[m]) begin
      e.i = xi;
      e.q = xq;
    end else if (cm[m]) begin
      e.i = sat(fdiv(pii + pqq, 2));
      e.q = sat(fdiv(pqi - piq, 2));
    end else begin
      e.i = sat(fdiv(pii - pqq, 2));
      e.q = sat(fdiv(piq + pqi, 2));
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && in_valid && in_ready)
      expq.push_back(model(in_i, in_q, lo_i, lo_q, int'(in_ch), conj_mask, bypass_mask,
                           cyc + 1, lat_chk));
    if (out_valid && !head_seen && expq.size() > 0) begin
      head_seen = 1;
      if (expq[0].lat) chk("latency", cyc - expq[0].edge_no, MIX_LATENCY);
    end
    if (out_valid && out_ready) begin
      if (gap_chk && last_hs >= 0) chk("release_gap", cyc - last_hs, 4);
      last_hs = cyc;
      tests++;
      assert (expq.size() > 0) else begin
        fails++;
        $error("FAIL spurious_output: got i=%0d q=%0d ch=%0d with nothing expected",
               out_i, out_q, out_ch);
      end
      if (expq.size() > 0) begin
        chk("out_i", out_i, expq[0].i);
        chk("out_q", out_q, expq[0].q);
        chk("out_ch", out_ch, expq[0].ch);
        void'(expq.pop_front());
        head_seen = 0;
        last_i = out_i;
        last_q = out_q;
        last_ch = int'(out_ch);
      end
    end
  end

  task automatic send(input int xi, input int xq, input int li, input int lq, input int ch);
    in_i = DSZ'(xi);
    in_q = DSZ'(xq);
    lo_i = DSZ'(li);
    lo_q = DSZ'(lq);
    in_ch = CHW'(ch);
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    tests++;
    assert (in_ready === 1'b1) else begin
      fails++;
      $error("FAIL send_timeout: in_ready=%0b expected 1", in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (expq.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    tests++;
    assert (expq.size() == 0) else begin
      fails++;
      $error("FAIL drain: %0d pending expected 0", expq.size());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd_val();
    int r = $urandom_range(0, 7);
    logic signed [15:0] v = 16'($urandom);
    if (r == 0) return -32768;
    if (r == 1) return 32767;
    return int'(v);
  endfunction

  task automatic send_rnd();
    conj_mask = NCH'($urandom);
    bypass_mask = NCH'($urandom);
    send(rnd_val(), rnd_val(), rnd_val(), rnd_val(), $urandom_range(0, 3));
  endtask

  initial begin
    int seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_i", out_i, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_out_ch", out_ch, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    lat_chk = 1;
    send(16384, 0, 16384, 0, 0);
    drain();
    chk("quarter_i", last_i, 4096);
    chk("quarter_q", last_q, 0);

    send(32767, 0, 32767, 0, 1);
    drain();
    chk("max_i", last_i, 16383);
    chk("max_q", last_q, 0);

    send(-32768, -32768, -32768, -32768, 1);
    drain();
    chk("neg_i", last_i, 0);
    chk("neg_q", last_q, 32767);
    conj_mask = 3'b010;
    send(-32768, -32768, -32768, -32768, 1);
    drain();
    chk("neg_conj_i", last_i, 32767);
    chk("neg_conj_q", last_q, 0);
    conj_mask = '0;

    bypass_mask = 3'b100;
    send(-5, 7, 1234, -999, 2);
    drain();
    chk("byp_i", last_i, -5);
    chk("byp_q", last_q, 7);
    chk("byp_ch", last_ch, 2);
    send(1000, -2000, 3000, 4000, 0);
    send(-5, 7, 100, 100, 2);
    send(-3000, 1500, -20000, 12345, 1);
    drain();

    bypass_mask = 3'b001;
    send(77, -88, 500, 500, 3);
    drain();
    chk("oor_i", last_i, 77);
    chk("oor_q", last_q, -88);
    chk("oor_ch", last_ch, 3);
    bypass_mask = '0;

    lat_chk = 0;
    fork
      begin
        repeat (6) send_rnd();
      end
      begin
        exp_t held;
        out_ready = 1'b0;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
          @(negedge clk);
          if (out_valid) seen = 1;
        end
        chk("stall_valid_seen", out_valid, 1);
        if (expq.size() > 0) held = expq[0];
        repeat (20) @(negedge clk);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_hold_i", out_i, held.i);
        chk("stall_hold_q", out_q, held.q);
        chk("stall_hold_ch", out_ch, held.ch);
        @(posedge clk);
        #1;
        last_hs = -1;
        gap_chk = 1;
        out_ready = 1'b1;
      end
    join
    drain();
    gap_chk = 0;

    rnd_done = 0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send_rnd();
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    conj_mask = '0;
    bypass_mask = '0;
    send(16384, 0, 16384, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    expq.delete();
    head_seen = 0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", in_ready, 1);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("midrst_no_valid", seen, 0);
    chk("midrst_out_i", out_i, 0);
    chk("midrst_out_q", out_q, 0);
    @(posedge clk);
    #1;

    lat_chk = 1;
    send(-12000, 9000, 25000, -7000, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multichannel_mixer.md
MULTICHANNEL_MIXER -- requirements
Module: multichannel_mixer

Interface
REQ-001 Parameter DSZ, default 16, SHALL set the signed I/Q data width for samples, LO and outputs.
REQ-002 Parameter NCH, default 4, SHALL set the number of channels; CHW = max(1, clog2(NCH)).
REQ-003 clk  input  1  clock; all logic SHALL be rising-edge synchronous.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  sample offered; in_ready  output  1  sample accepted when both high.
REQ-006 in_i, in_q  input  DSZ signed  sample I/Q; lo_i, lo_q  input  DSZ signed  LO I/Q; in_ch  input  CHW  channel tag; all qualified by in_valid.
REQ-007 conj_mask, bypass_mask  input  NCH  per-channel mode bits, sampled at acceptance.
REQ-008 out_valid  output  1  result present; out_ready  input  1  result consumed when both high.
REQ-009 out_i, out_q  output  DSZ signed  result; out_ch  output  CHW  tag of the accepted sample.

Function
REQ-010 One shared DSZ x DSZ signed multiplier SHALL compute the four products ii=in_i*lo_i, qq=in_q*lo_q, iq=in_i*lo_q, qi=in_q*lo_i per sample, one product per cycle.
REQ-011 Each product SHALL be scaled as P = sat_DSZ(floor((x*y + 2^(DSZ-2)) / 2^(DSZ-1))), i.e. round half up, then saturate to DSZ bits.
REQ-012 With conj_mask[in_ch]=0: out_i = sat_DSZ(floor((Pii - Pqq)/2)), out_q = sat_DSZ(floor((Piq + Pqi)/2)).
REQ-013 With conj_mask[in_ch]=1 (multiply by conj(LO)): out_i = sat_DSZ(floor((Pii + Pqq)/2)), out_q = sat_DSZ(floor((Pqi - Piq)/2)).
REQ-014 Sums SHALL use DSZ+2-bit signed accumulators; floor is arithmetic shift right by 1.
REQ-015 With bypass_mask[in_ch]=1: out_i=in_i, out_q=in_q unmodified, with identical latency and ordering.
REQ-016 Pipeline: accept at edge T; out_valid SHALL rise after edge T+8 with no stall (latency constant MIX_LATENCY=8).
REQ-017 Throughput: one sample per 4 cycles; in_ready SHALL permit back-to-back acceptance at T and T+4.
REQ-018 FSM states ISSUE0..ISSUE3 cycle the operand select (ii, qq, iq, qi order); IDLE when no sample is pending; ISSUE3 -> ISSUE0 if a new sample is accepted, else -> IDLE.
REQ-019 Stall: while out_valid=1 and out_ready=0 the entire pipeline, FSM and accumulators SHALL freeze, and in_ready SHALL be 0.
REQ-020 out_i/out_q/out_ch SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Results SHALL leave in acceptance order; no sample SHALL be dropped or duplicated.
REQ-022 in_ch >= NCH SHALL be treated as channel 0 for mask lookup but passed unchanged on out_ch.

Reset
REQ-023 On reset: FSM=IDLE; in_ready=0 during reset, 1 on the first cycle after.
REQ-024 On reset: out_valid=0, out_i=0, out_q=0, out_ch=0, and all accumulators and pipeline registers zeroed.
REQ-025 Reset mid-operation SHALL discard all in-flight samples; no out_valid pulse from pre-reset samples.

Structure
REQ-026 DSZ default, NCH default and MIX_LATENCY SHALL live in the shared DSP package.
REQ-027 Saturation SHALL reuse the existing saturator sub-module (ISZ=DSZ+1, OSZ=DSZ): one instance for products, two for outputs.

Verification (DSZ=16)
REQ-028 in=(16384,0), lo=(16384,0), conj=0 -> out=(4096,0) after exactly 8 cycles.
REQ-029 in=(32767,0), lo=(32767,0) -> Pii=32766, out=(16383,0).
REQ-030 in=(-32768,-32768), lo=(-32768,-32768): conj=0 -> (0,32767); conj=1 on that channel -> (32767,0).
REQ-031 bypass channel 2, in=(-5,7) -> out=(-5,7), out_ch=2, latency 8; interleaved with non-bypass channels, order preserved.
REQ-032 Continuous in_valid with out_ready low 20 cycles -> in_ready low, outputs held, no loss; release -> results in order at 1 per 4 cycles.
REQ-033 Reset asserted 3 cycles after acceptance -> no out_valid afterward, out=(0,0), in_ready=1 the cycle after reset deasserts.
